rcom_cmd_sequencer: RTL and testbench

- Hardware command sequencer for driving the remote-command (RCOM) transmitter in self-test and scripted runs.
- Buffers up to DEPTH commands in a FIFO and issues them one at a time with a single-cycle snd_cmd pulse.
- After each command it waits for cmd_snt and then for the robot's response byte; every wait is timeout-guarded.
- Outcome is reported through a done pulse plus sticky pass/fail flags and the index of the failing command; sits between host/scripted control and the RCOM transmitter/receiver.

---
 rtl/rcom_cmd_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_rcom_cmd_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcom_cmd_sequencer.sv
// RCOM command sequencer: queues commands and issues them to the transmitter
// one at a time, guarding each wait with a timeout and reporting pass/fail.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_cmd, wr_data       push a command into the FIFO
//   start                 begin a run (sampled in IDLE only)
//   clr_err               clear sticky error flags
//   cmd_snt               transmitter finished sending cmd
//   resp_rdy, resp        response byte from the robot
//   cmd, snd_cmd          command register and one-cycle send strobe
//   full, empty, count    FIFO status
//   busy, done            run in progress / end-of-run pulse
//   fail, timeout_err,
//   bad_resp, overflow    sticky outcome flags
//   err_idx               run index of the failing command
module rcom_cmd_sequencer #(
    parameter int          CMD_W   = 16,
    parameter int          DEPTH   = 8,
    parameter int          TMO_CYC = 1000000,
    parameter logic [7:0]  RESP_OK = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_cmd,
    input  logic [CMD_W-1:0]         wr_data,
    input  logic                     start,
    input  logic                     clr_err,
    input  logic                     cmd_snt,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic [CMD_W-1:0]         cmd,
    output logic                     snd_cmd,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic                     timeout_err,
    output logic                     bad_resp,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   err_idx
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TMO_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx;
    logic [TW-1:0]    tmr;

    logic pop, flush, push_ok, push_drop;
    logic idx_clr, idx_inc, set_to, set_bad;
    logic waiting, tmr_exp;

    // FIFO status
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

    // A push is dropped silently during a flush; only a full FIFO without
    // a same-cycle pop counts as overflow.
    assign push_ok   = wr_cmd && !flush && (!full || pop);
    assign push_drop = wr_cmd && !flush && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    // Wait-state timer; restarts on any state change
    assign waiting = (state == WAIT_SNT) || (state == WAIT_RESP);
    assign tmr_exp = (tmr == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (waiting && (state_n == state)) begin
            tmr <= tmr + 1'b1;
        end else begin
            tmr <= '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and control strobes; events take priority over timeout
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        flush   = 1'b0;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        set_to  = 1'b0;
        set_bad = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        idx_clr = 1'b1;
                        state_n = SEND;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SEND: state_n = WAIT_SNT;
            WAIT_SNT: begin
                if (cmd_snt) begin
                    state_n = WAIT_RESP;
                end else if (tmr_exp) begin
                    set_to  = 1'b1;
                    flush   = 1'b1;
                    state_n = DONE;
                end
            end
            WAIT_RESP: begin
                if (resp_rdy) begin
                    if (resp == RESP_OK) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            idx_inc = 1'b1;
                            state_n = SEND;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        set_bad = 1'b1;
                        flush   = 1'b1;
                        state_n = DONE;
                    end
                end else if (tmr_exp) begin
                    set_to  = 1'b1;
                    flush   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign snd_cmd = (state == SEND);
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);

    // Command register and run index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd <= '0;
            idx <= '0;
        end else begin
            if (pop)     cmd <= mem[rd_ptr];
            if (idx_clr) idx <= '0;
            else if (idx_inc) idx <= idx + 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as clr_err wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            bad_resp    <= 1'b0;
            overflow    <= 1'b0;
            err_idx     <= '0;
        end else begin
            if (set_to)       timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
            if (set_bad)      bad_resp    <= 1'b1;
            else if (clr_err) bad_resp    <= 1'b0;
            if (push_drop)    overflow    <= 1'b1;
            else if (clr_err) overflow    <= 1'b0;
            if (set_to || set_bad) err_idx <= idx;
        end
    end

    assign fail = timeout_err | bad_resp | overflow;

endmodule

// File: tb/tb_rcom_cmd_sequencer.sv
// Self-checking bench for rcom_cmd_sequencer (DEPTH=4, TMO_CYC=16).
// A queue-based run model is compared every cycle, plus directed literals.
module tb_rcom_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        wr_cmd = 0;
    logic [15:0] wr_data = 0;
    logic        start = 0;
    logic        clr_err = 0;
    logic        cmd_snt = 0;
    logic        resp_rdy = 0;
    logic [7:0]  resp = 0;

    logic [15:0] cmd;
    logic        snd_cmd, full, empty, busy, done, fail;
    logic        timeout_err, bad_resp, overflow;
    logic [2:0]  count, err_idx;

    rcom_cmd_sequencer #(
        .CMD_W(16), .DEPTH(DEPTH), .TMO_CYC(TMO), .RESP_OK(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_cmd(wr_cmd), .wr_data(wr_data),
        .start(start), .clr_err(clr_err), .cmd_snt(cmd_snt),
        .resp_rdy(resp_rdy), .resp(resp), .cmd(cmd), .snd_cmd(snd_cmd),
        .full(full), .empty(empty), .count(count), .busy(busy),
        .done(done), .fail(fail), .timeout_err(timeout_err),
        .bad_resp(bad_resp), .overflow(overflow), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // ---------------- run model ----------------
    typedef enum {M_IDLE, M_PULSE, M_SNT, M_RSP, M_END} mph_t;
    mph_t        ph = M_IDLE;
    logic [15:0] q[$];
    logic [15:0] m_cmd = 0;
    int          left = 0, k = 0, m_eidx = 0;
    bit          m_to = 0, m_bad = 0, m_ovf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = M_IDLE; q.delete(); m_cmd = 0; left = 0; k = 0;
            m_eidx = 0; m_to = 0; m_bad = 0; m_ovf = 0;
        end else begin : mdl
            bit e_to, e_bad, e_ovf;
            e_to = 0; e_bad = 0; e_ovf = 0;
            case (ph)
                M_IDLE: if (start) begin
                    if (q.size() != 0) begin
                        m_cmd = q.pop_front(); k = 0; ph = M_PULSE;
                    end else ph = M_END;
                end
                M_PULSE: begin ph = M_SNT; left = TMO; end
                M_SNT: begin
                    if (cmd_snt) begin ph = M_RSP; left = TMO; end
                    else begin
                        left--;
                        if (left == 0) begin e_to = 1; ph = M_END; end
                    end
                end
                M_RSP: begin
                    if (resp_rdy) begin
                        if (resp == 8'hA5) begin
                            if (q.size() != 0) begin
                                m_cmd = q.pop_front(); k++; ph = M_PULSE;
                            end else ph = M_END;
                        end else begin e_bad = 1; ph = M_END; end
                    end else begin
                        left--;
                        if (left == 0) begin e_to = 1; ph = M_END; end
                    end
                end
                M_END: ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
            if (e_to || e_bad) q.delete();
            else if (wr_cmd) begin
                if (q.size() < DEPTH) q.push_back(wr_data);
                else e_ovf = 1;
            end
            if (clr_err) begin m_to = 0; m_bad = 0; m_ovf = 0; end
            if (e_to) m_to = 1;
            if (e_bad) m_bad = 1;
            if (e_ovf) m_ovf = 1;
            if (e_to || e_bad) m_eidx = k;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd", cmd, m_cmd);
            chk("snd_cmd", snd_cmd, ph == M_PULSE);
            chk("done", done, ph == M_END);
            chk("busy", busy, ph != M_IDLE);
            chk("count", count, q.size());
            chk("full", full, q.size() == DEPTH);
            chk("empty", empty, q.size() == 0);
            chk("timeout_err", timeout_err, m_to);
            chk("bad_resp", bad_resp, m_bad);
            chk("overflow", overflow, m_ovf);
            chk("fail", fail, m_to | m_bad | m_ovf);
            chk("err_idx", err_idx, m_eidx);
        end
    end

    // ---------------- monitor ----------------
    int          snd_cnt = 0, snd_cyc = 0, done_cyc = 0;
    logic [15:0] snd_log[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (snd_cmd) begin
            snd_cnt++; snd_log.push_back(cmd); snd_cyc = cyc;
        end
        if (done) done_cyc = cyc;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic push(input logic [15:0] d);
        wr_cmd = 1; wr_data = d; step(); wr_cmd = 0;
    endtask

    task automatic go();
        start = 1; step(); start = 0;
    endtask

    task automatic clr();
        clr_err = 1; step(); clr_err = 0;
    endtask

    task automatic wait_snd(output bit got);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (snd_cmd === 1'b1) got = 1;
            else step();
        end
        if (!got) chk("wait_snd_timeout", 0, 1);
    endtask

    task automatic wait_done(output bit got);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done === 1'b1) got = 1;
            else step();
        end
        if (!got) chk("wait_done_timeout", 0, 1);
    endtask

    task automatic answer(input logic [7:0] b);
        bit got;
        wait_snd(got);
        if (!got) return;
        step();
        cmd_snt = 1; step(); cmd_snt = 0;
        resp_rdy = 1; resp = b; step(); resp_rdy = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int s0;
        repeat (3) step();
        chk("rst_cmd", cmd, 0);
        chk("rst_snd", snd_cmd, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1;
        chk_en = 1;
        step();

        // S1: three commands, all acknowledged
        snd_log.delete(); s0 = snd_cnt;
        push(16'h2001); push(16'h4002); push(16'h6003);
        chk("s1_count", count, 3);
        go();
        answer(8'hA5); answer(8'hA5); answer(8'hA5);
        chk("s1_done_next", done, 1);
        chk("s1_fail", fail, 0);
        step();
        chk("s1_nsnd", snd_cnt - s0, 3);
        chk("s1_cmd0", snd_log.size() > 0 ? snd_log[0] : 16'hxxxx, 16'h2001);
        chk("s1_cmd1", snd_log.size() > 1 ? snd_log[1] : 16'hxxxx, 16'h4002);
        chk("s1_cmd2", snd_log.size() > 2 ? snd_log[2] : 16'hxxxx, 16'h6003);
        chk("s1_empty", empty, 1);

        // S2: overflow, run still completes
        s0 = snd_cnt;
        for (int i = 0; i < 5; i++) begin
            wr_cmd = 1; wr_data = 16'h0100 + 16'(i); step();
            if (i == 3) begin
                chk("s2_full4", full, 1);
                chk("s2_cnt4", count, 4);
            end
        end
        wr_cmd = 0;
        chk("s2_ovf", overflow, 1);
        chk("s2_cnt5", count, 4);
        go();
        for (int i = 0; i < 4; i++) answer(8'hA5);
        wait_done(got);
        chk("s2_fail", fail, 1);
        step();
        chk("s2_nsnd", snd_cnt - s0, 4);
        clr();

        // S3: bad response on second command
        s0 = snd_cnt;
        push(16'hA001); push(16'hA002); push(16'hA003);
        go();
        answer(8'hA5); answer(8'h5A);
        wait_done(got);
        chk("s3_bad", bad_resp, 1);
        chk("s3_eidx", err_idx, 1);
        chk("s3_count", count, 0);
        step(); step();
        chk("s3_nsnd", snd_cnt - s0, 2);
        clr();

        // S4: cmd_snt never arrives
        push(16'hB001);
        go();
        wait_snd(got);
        wait_done(got);
        chk("s4_lat", done_cyc - snd_cyc, 17);
        chk("s4_to", timeout_err, 1);
        chk("s4_eidx", err_idx, 0);
        step();
        clr();
        chk("s4_clr_fail", fail, 0);
        chk("s4_clr_to", timeout_err, 0);
        chk("s4_clr_bad", bad_resp, 0);
        chk("s4_clr_ovf", overflow, 0);

        // S5: response lands on the expiry cycle
        push(16'hC001);
        go();
        wait_snd(got);
        step();
        cmd_snt = 1; step(); cmd_snt = 0;
        repeat (15) step();
        resp_rdy = 1; resp = 8'hA5; step(); resp_rdy = 0;
        chk("s5_done", done, 1);
        chk("s5_to", timeout_err, 0);
        step();

        // S6: async reset mid-run, then empty start
        for (int i = 0; i < 5; i++) push(16'hD000 + 16'(i));
        go();
        wait_snd(got);
        step(); step();
        #2 rst_n = 0;
        #1;
        chk("s6_cmd", cmd, 0);
        chk("s6_snd", snd_cmd, 0);
        chk("s6_full", full, 0);
        chk("s6_empty", empty, 1);
        chk("s6_count", count, 0);
        chk("s6_busy", busy, 0);
        chk("s6_done", done, 0);
        chk("s6_ovf", overflow, 0);
        chk("s6_fail", fail, 0);
        step();
        rst_n = 1;
        step();
        s0 = snd_cnt;
        go();
        chk("s6_edone", done, 1);
        chk("s6_esnd", snd_cmd, 0);
        step(); step();
        chk("s6_nsnd", snd_cnt - s0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
